// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the board-level reset sequencer.
// Contents:
//   state_t       - sequencer state encoding
//   CAUSE_*       - encodings reported on the cause output
//   fault_cause() - picks the reported cause when several faults coincide
package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_POR    = 2'b00;
  localparam logic [1:0] CAUSE_LOCK   = 2'b01;
  localparam logic [1:0] CAUSE_BUTTON = 2'b10;
  localparam logic [1:0] CAUSE_SOFT   = 2'b11;

  // When faults coincide, the most fundamental one is reported.
  // Losing the clock source outranks a user press, and a user press outranks software.
  function automatic logic [1:0] fault_cause(input logic lock_lost,
                                             input logic button_pressed);
    logic [1:0] result;
    if (lock_lost)
      result = CAUSE_LOCK;
    else if (button_pressed)
      result = CAUSE_BUTTON;
    else
      result = CAUSE_SOFT;
    return result;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_debounce.sv
// Synchroniser plus debounce filter for an asynchronous push-button.
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   raw_in    - raw button level, asynchronous and possibly bouncing
//   debounced - filtered button state, 1 = pressed regardless of ACTIVE_LOW
module sync_debounce import reset_seq_pkg::*; #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic debounced
);

  // The raw level that corresponds to "not pressed".
  // The synchroniser resets to this level so nothing looks pressed after reset.
  localparam logic IDLE_LEVEL = ACTIVE_LOW;

  // The counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       stable_cnt;
  logic                   pressed;

  // Plain shift-register synchroniser; the last stage is the first safe sample.
  always_ff @(posedge clk) begin
    if (rst)
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
    else
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
  end

  // Normalise polarity so that 1 always means pressed.
  assign pressed = ACTIVE_LOW ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];

  // The output only flips on the DEBOUNCE_CYCLES-th consecutive cycle on which the
  // synchronised level disagrees with it.
  // Any agreeing cycle restarts the count, so short bounces are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      debounced  <= 1'b0;
      stable_cnt <= '0;
    end else if (pressed != debounced) begin
      if (stable_cnt == CNT_MAX) begin
        debounced  <= pressed;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end else begin
      stable_cnt <= '0;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Board-level reset controller.
// It waits for PLL lock and a released button, then releases NUM_CHANNELS reset
// domains one after another.
// It re-asserts all of them on lock loss, a button press or a software request,
// and it records why.
// Ports:
//   clk         - system clock
//   rst         - synchronous active-high reset
//   locked_in   - PLL lock, asynchronous
//   button_in   - raw reset button, asynchronous, may bounce
//   soft_reset  - one-cycle software reset request, synchronous
//   rst_out     - per-domain reset, active-high
//   rst_n_out   - registered inverse of rst_out
//   ready       - every channel released
//   cause       - last reset cause (see reset_seq_pkg CAUSE_*)
//   reset_count - saturating count of fault events
module reset_sequencer import reset_seq_pkg::*; #(
  parameter int NUM_CHANNELS      = 4,
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int HOLD_CYCLES       = 8,
  parameter int STAGGER_CYCLES    = 4,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    locked_in,
  input  logic                    button_in,
  input  logic                    soft_reset,
  output logic [NUM_CHANNELS-1:0] rst_out,
  output logic [NUM_CHANNELS-1:0] rst_n_out,
  output logic                    ready,
  output logic [1:0]              cause,
  output logic [7:0]              reset_count
);

  // Each counter is sized for its largest loaded value, with a 1-bit minimum.
  localparam int HOLD_W = (HOLD_CYCLES > 1)    ? $clog2(HOLD_CYCLES)    : 1;
  localparam int STAG_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
  localparam int CH_W   = (NUM_CHANNELS > 1)   ? $clog2(NUM_CHANNELS)   : 1;

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STAG_W-1:0] STAG_LOAD = STAG_W'(STAGGER_CYCLES - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CHANNELS - 1);

  state_t                  state;
  logic [SYNC_STAGES-1:0]  lock_sync;
  logic                    lock_s;
  logic                    btn_d;
  logic                    fault;
  logic                    release_now;
  logic [HOLD_W-1:0]       hold_cnt;
  logic [STAG_W-1:0]       stag_cnt;
  logic [CH_W-1:0]         chan_idx;
  logic [NUM_CHANNELS-1:0] release_mask;

  // The lock signal has no bounce, so it only needs a synchroniser.
  // Clearing it on reset means the sequencer always waits for a fresh lock.
  always_ff @(posedge clk) begin
    if (rst)
      lock_sync <= '0;
    else
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], locked_in};
  end

  assign lock_s = lock_sync[SYNC_STAGES-1];

  sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (BUTTON_ACTIVE_LOW)
  ) u_button (
    .clk      (clk),
    .rst      (rst),
    .raw_in   (button_in),
    .debounced(btn_d)
  );

  assign fault = !lock_s || btn_d || soft_reset;

  // HOLD and RELEASE share the release step.
  // The channel index is still 0 when the hold counter expires, so the same logic
  // frees channel 0 and every later channel.
  always_comb begin
    release_mask = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      if (chan_idx == CH_W'(i))
        release_mask[i] = 1'b1;
    release_now = ((state == HOLD) && (hold_cnt == '0)) ||
                  ((state == RELEASE) && (stag_cnt == '0));
  end

  // Main sequencer.
  // A fault in any active state wins over normal progress and returns to WAIT_LOCK.
  // Only the transition out of an active state counts as a reset event, so inputs
  // seen while already waiting are neither counted nor recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_LOCK;
      rst_out     <= '1;
      rst_n_out   <= '0;
      ready       <= 1'b0;
      cause       <= CAUSE_POR;
      reset_count <= '0;
      hold_cnt    <= '0;
      stag_cnt    <= '0;
      chan_idx    <= '0;
    end else if (state != WAIT_LOCK && fault) begin
      state     <= WAIT_LOCK;
      rst_out   <= '1;
      rst_n_out <= '0;
      ready     <= 1'b0;
      chan_idx  <= '0;
      cause     <= fault_cause(!lock_s, btn_d);
      if (reset_count != 8'hFF)
        reset_count <= reset_count + 1'b1;
    end else begin
      unique case (state)
        WAIT_LOCK: begin
          if (lock_s && !btn_d) begin
            state    <= HOLD;
            hold_cnt <= HOLD_LOAD;
          end
        end
        HOLD, RELEASE: begin
          if (release_now) begin
            rst_out   <= rst_out & ~release_mask;
            rst_n_out <= rst_n_out | release_mask;
            stag_cnt  <= STAG_LOAD;
            if (chan_idx == LAST_CH) begin
              ready <= 1'b1;
              state <= RUN;
            end else begin
              chan_idx <= chan_idx + 1'b1;
              state    <= RELEASE;
            end
          end else if (state == HOLD) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else begin
            stag_cnt <= stag_cnt - 1'b1;
          end
        end
        RUN: begin
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
